vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  VGA display controller in the pixel-clock domain; read side of the dual-port VRAM (port B).
//  Generates 640x480@60 timing and issues a linear VRAM read address per active pixel.
//  Registers returned 12-bit pixels {R[11:8],G[7:4],B[3:0]} to RGB pins, aligned with HS/VS.
//  The AHB side writes VRAM; this block never writes it.
// PARAMETERS
//  H_ACTIVE 640  visible pixels/line;  H_FP 16, H_SYNC 96, H_BP 48 (H_TOTAL 800)
//  V_ACTIVE 480  visible lines/frame;  V_FP 10, V_SYNC 2, V_BP 33 (V_TOTAL 525)
//  SYNC_POL 0    sync active level (0 = active-low)
//  RD_LAT   1    VRAM port-B read latency in clocks (addr -> IO_VGA_DATA)
// PORTS
//  IO_VGA_CLK   in   1   pixel clock (25 MHz), sole clock
//  IO_VGA_RST   in   1   asynchronous, active-high reset
//  IO_VGA_ADDR  out  19  VRAM read address = y*H_ACTIVE + x
//  IO_VGA_DATA  in   12  VRAM read data, valid RD_LAT clocks after address
//  en           in   1   display enable, sampled at frame start
//  VGA_R/G/B    out  4 each  pixel colour, registered
//  VGA_HS/VS    out  1   sync outputs, registered
//  vblank       out  1   high while v_cnt >= V_ACTIVE (undelayed)
//  frame_start  out  1   1-clk pulse when h_cnt==0 && v_cnt==0 (undelayed)
// BEHAVIOUR
//  - Reset: h_cnt=v_cnt=0, addr=0, en_frame=0, pipeline cleared; RGB=0, HS/VS=!SYNC_POL,
//    vblank=0; frame_start=1 in first clock after release. Reset mid-frame: immediate, no clock.
//  - h_cnt 0..H_TOTAL-1, wraps to 0; v_cnt increments on h wrap, wraps 0 after V_TOTAL-1.
//  - active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE). No multiplier: addr register increments by 1
//    after each active clock; cleared to 0 when (h,v)==(H_TOTAL-1,V_TOTAL-1). Holds outside
//    active. IO_VGA_ADDR = addr (registered). Max value H_ACTIVE*V_ACTIVE-1 = 307199.
//  - hs_raw = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else !SYNC_POL;
//    vs_raw same on v_cnt with V_ACTIVE+V_FP .. +V_SYNC-1 (whole lines).
//  - Pipeline: active, hs_raw, vs_raw delayed RD_LAT clocks via shift regs, then one output
//    register stage. Total counter->pin latency = RD_LAT+1 clocks for RGB, HS, VS alike.
//  - RGB reg <= (active_d && en_frame) ? IO_VGA_DATA : 12'h000. Blanking always forces 0.
//  - en_frame <= en on the clock edge where frame_start=1; mid-frame en changes take effect
//    at next frame only. Syncs run regardless of en.
//  - No handshake: VRAM port B is read every clock; data beyond active region ignored.
// TESTING
//  1. Release reset, free run -> HS period 800 clks, HS low 96 clks starting 656 clks after
//     line start; VS period 420000 clks, low 1600 clks; frame_start every 420000 clks.
//  2. Monitor IO_VGA_ADDR on active clocks -> line0 0..639, line1 starts 640, last pixel
//     307199, next frame restarts at 0; value held constant through blanking.
//  3. VRAM model returns addr[11:0] after 1 clk, en=1 -> pixel x=5,y=0 gives RGB=12'h005
//     exactly 2 clks after addr 5 issued; first HS falling edge 658 clks after frame_start.
//  4. VRAM model returns 12'hFFF always -> RGB=0 in every clock of horizontal and vertical
//     blanking (delayed window), 12'hFFF elsewhere.
//  5. en=1, drop en to 0 at line 200 -> rest of frame displays data; next frame RGB all 0,
//     HS/VS timing unchanged; raise en -> display resumes the following frame.
//  6. Assert IO_VGA_RST mid-line (no clock edge) -> RGB=0, HS=VS=1, vblank=0 immediately;
//     release -> counters restart at (0,0), frame_start pulses in first clock.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator and VRAM port-B reader; registers returned pixels to the RGB pins
// with HS/VS delayed through the same pipeline so colour and sync stay aligned.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int RD_LAT   = 1
) (
    input  logic        IO_VGA_CLK,
    input  logic        IO_VGA_RST,
    output logic [18:0] IO_VGA_ADDR,
    input  logic [11:0] IO_VGA_DATA,
    input  logic        en,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        vblank,
    output logic        frame_start
);
    localparam logic [9:0] HA     = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VA     = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_cnt, v_cnt;
    logic [18:0] addr;
    logic        h_last, v_last, active, hs_raw, vs_raw, en_frame;
    logic        act_sr [RD_LAT];
    logic        hs_sr  [RD_LAT];
    logic        vs_sr  [RD_LAT];

    always_comb begin
        h_last      = h_cnt == H_LAST;
        v_last      = v_cnt == V_LAST;
        active      = (h_cnt < HA) && (v_cnt < VA);
        hs_raw      = (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : !SYNC_POL;
        vs_raw      = (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : !SYNC_POL;
        vblank      = v_cnt >= VA;
        frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

    assign IO_VGA_ADDR = addr;

    always_ff @(posedge IO_VGA_CLK or posedge IO_VGA_RST) begin
        if (IO_VGA_RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
            if (h_last)
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Linear address is accumulated rather than computed as y*H_ACTIVE+x.
    always_ff @(posedge IO_VGA_CLK or posedge IO_VGA_RST) begin
        if (IO_VGA_RST)
            addr <= '0;
        else if (h_last && v_last)
            addr <= '0;
        else if (active)
            addr <= addr + 19'd1;
    end

    always_ff @(posedge IO_VGA_CLK or posedge IO_VGA_RST) begin
        if (IO_VGA_RST)
            en_frame <= 1'b0;
        else if (frame_start)
            en_frame <= en;
    end

    // Control delayed by the VRAM read latency, then one output register stage.
    always_ff @(posedge IO_VGA_CLK or posedge IO_VGA_RST) begin
        if (IO_VGA_RST) begin
            for (int i = 0; i < RD_LAT; i++) begin
                act_sr[i] <= 1'b0;
                hs_sr[i]  <= !SYNC_POL;
                vs_sr[i]  <= !SYNC_POL;
            end
            {VGA_R, VGA_G, VGA_B} <= 12'h000;
            VGA_HS <= !SYNC_POL;
            VGA_VS <= !SYNC_POL;
        end else begin
            act_sr[0] <= active;
            hs_sr[0]  <= hs_raw;
            vs_sr[0]  <= vs_raw;
            for (int i = 1; i < RD_LAT; i++) begin
                act_sr[i] <= act_sr[i-1];
                hs_sr[i]  <= hs_sr[i-1];
                vs_sr[i]  <= vs_sr[i-1];
            end
            {VGA_R, VGA_G, VGA_B} <= (act_sr[RD_LAT-1] && en_frame) ? IO_VGA_DATA : 12'h000;
            VGA_HS <= hs_sr[RD_LAT-1];
            VGA_VS <= vs_sr[RD_LAT-1];
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout on a reduced 15x10 raster so whole frames fit.
module tb_vga_scanout;
    localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2;
    localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs, vs, vb, fs;
        logic [18:0] addr;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b1, mode = 1'b0;
    logic [18:0] addr;
    logic [11:0] data = 12'h000;
    logic [3:0]  r, g, b;
    logic        hs, vs, vblank, frame_start;
    int          checks = 0, failures = 0, run_id = 0;
    int          fen [4];
    exp_t        q [$];

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0), .RD_LAT(1)
    ) dut (
        .IO_VGA_CLK(clk), .IO_VGA_RST(rst), .IO_VGA_ADDR(addr), .IO_VGA_DATA(data),
        .en(en), .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs),
        .vblank(vblank), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // VRAM port B: one-clock read latency
    always @(posedge clk) data <= mode ? 12'hFFF : addr[11:0];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", n, $time, a, e);
        end
    endtask

    // Expected pin state after s clock edges since reset release
    function automatic exp_t expect_at(int s);
        exp_t e;
        int h, v, h2, v2;
        h = s % HT;
        v = (s / HT) % VT;
        e.vb = v >= VA;
        e.fs = (h == 0) && (v == 0);
        e.addr = 19'(v < VA ? (h < HA ? v * HA + h : (v + 1) * HA) : HA * VA);
        e.rgb = 12'h000;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (s >= 2) begin
            h2 = (s - 2) % HT;
            v2 = ((s - 2) / HT) % VT;
            e.hs = !(h2 >= HA + HFP && h2 < HA + HFP + HSW);
            e.vs = !(v2 >= VA + VFP && v2 < VA + VFP + VSW);
            if (h2 < HA && v2 < VA && fen[(s - 2) / FT] != 0)
                e.rgb = mode ? 12'hFFF : 12'((v2 * HA + h2) % 4096);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rgb", {r, g, b}, e.rgb);
            chk("hs", hs, e.hs);
            chk("vs", vs, e.vs);
            chk("vblank", vblank, e.vb);
            chk("frame_start", frame_start, e.fs);
            chk("addr", addr, e.addr);
        end
    end

    task automatic run(input int n);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rgb", {r, g, b}, 12'h000);
        chk("rel_hs", hs, 1'b1);
        chk("rel_vs", vs, 1'b1);
        chk("rel_vblank", vblank, 1'b0);
        chk("rel_frame_start", frame_start, 1'b1);
        chk("rel_addr", addr, 19'd0);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            if (run_id == 1 && k == 3 * HT) en = 1'b0;
            if (run_id == 1 && k == FT + 50) en = 1'b1;
            if (k % FT == 0) fen[k / FT] = int'(en);
            q.push_back(expect_at(k + 1));
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_rgb", {r, g, b}, 12'h000);
        chk("rst_hs", hs, 1'b1);
        chk("rst_vs", vs, 1'b1);
        chk("rst_vblank", vblank, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        run_id = 1;
        mode = 1'b0;
        run(2 * FT + 7 * HT + 4);
        mid_reset();
        run_id = 2;
        mode = 1'b1;
        en = 1'b1;
        repeat (2) @(posedge clk);
        run(FT + 2 * HT + 5);
        mid_reset();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
